// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision sequential adder:
// FSM state encodings, slice width and an index-width helper.
package mp_add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle for mp_add_seq.
// slave  = the adder block, master = the producer/consumer driving it.
interface mp_add_seq_if #(
  parameter int NWORDS = 4
);
  localparam int W = 16 * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/mp_add_seq_cla16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups
// whose group carries are themselves produced by a lookahead unit.
module cla16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_group
      localparam int B = 4 * gi;
      // Bit carries inside the group, all derived from the group carry-in.
      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);
      // Group generate/propagate for the second lookahead level.
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
    end
  endgenerate

  // Second-level lookahead across the four groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & cin);

  assign s    = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one shared 16-bit CLA processes one slice
// per cycle, LSB first. Subtraction is A + ~B + 1, with the inversion done
// at capture and the +1 seeded into the carry register.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input logic           clk,
  input logic           rst,
  mp_add_seq_if.slave   bus
);

  localparam int W  = SLICE_W * NWORDS;
  localparam int IW = idx_width(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;      // already inverted for subtraction
  logic                 sub_reg;
  logic                 carry_reg;
  logic [IW-1:0]        idx_reg;
  logic [SLICE_W-1:0]   sum_words [NWORDS];
  logic                 cout_reg;
  logic                 ovf_reg;

  logic [SLICE_W-1:0]   a_words [NWORDS];
  logic [SLICE_W-1:0]   b_words [NWORDS];
  logic [SLICE_W-1:0]   cla_a;
  logic [SLICE_W-1:0]   cla_b;
  logic [SLICE_W-1:0]   cla_s;
  logic                 cla_cout;
  logic                 last_slice;
  logic                 accept;

  // Word views of the captured operands and of the result register.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      assign a_words[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_words[gi] = b_reg[gi*SLICE_W +: SLICE_W];
      assign bus.sum[gi*SLICE_W +: SLICE_W] = sum_words[gi];
    end
  endgenerate

  assign cla_a      = a_words[idx_reg];
  assign cla_b      = b_words[idx_reg];
  assign last_slice = (idx_reg == LAST_IDX);
  assign accept     = (state_reg == IDLE) && bus.in_valid;

  cla16bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_reg),
    .s    (cla_s),
    .cout (cla_cout)
  );

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: accept in IDLE, step slices in RUN, hold result in DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_slice)    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Operand capture and per-slice datapath; result regs hold after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) sum_words[i] <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      sub_reg   <= bus.sub;
      carry_reg <= bus.sub;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      sum_words[idx_reg] <= cla_s;
      carry_reg          <= cla_cout;
      if (last_slice) begin
        cout_reg <= cla_cout;
        // Overflow: like-signed operands (after inversion) giving a sum of
        // the other sign. The current adder MSB is the result sign bit.
        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (cla_s[SLICE_W-1] != a_reg[W-1]);
      end else begin
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

  // The captured mode is fully encoded in b_reg and the carry seed; keep
  // the register observable in simulation only.
  logic sub_unused;
  assign sub_unused = sub_reg;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (NWORDS=4): checks reset state, latency,
// add/sub results, flags, backpressure hold, handoff and mid-run reset.
module tb_mp_add_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mp_add_seq_if #(.NWORDS(NW)) bus ();

  mp_add_seq #(.NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operation, count edges to out_valid, hold the result for
  // 'hold' cycles with out_ready=0, then deliver and check the handoff.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int hold);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, W'(bus.in_ready), W'(1));
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = a ^ b; bus.sub = ~sub;   // must be ignored
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, W'(n), W'(NW));
    chk({tag, " sum"}, bus.sum, exp_sum);
    chk({tag, " cout"}, W'(bus.cout), W'(exp_cout));
    chk({tag, " ovf"}, W'(bus.ovf), W'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold sum"}, bus.sum, exp_sum);
      chk({tag, " hold flags"}, W'({bus.cout, bus.ovf}), W'({exp_cout, exp_ovf}));
      chk({tag, " hold in_ready"}, W'(bus.in_ready), W'(0));
      chk({tag, " hold out_valid"}, W'(bus.out_valid), W'(1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " post out_valid"}, W'(bus.out_valid), W'(0));
    chk({tag, " post in_ready"}, W'(bus.in_ready), W'(1));
    chk({tag, " post sum kept"}, bus.sum, exp_sum);
    $display("[TB] %s: a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d latency=%0d",
             tag, a, b, sub, bus.sum, bus.cout, bus.ovf, n);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sub = 1'b0;
    bus.a = '0; bus.b = '0;
    #1;
    chk("reset in_ready", W'(bus.in_ready), W'(1));
    chk("reset out_valid", W'(bus.out_valid), W'(0));
    chk("reset sum", bus.sum, '0);
    chk("reset flags", W'({bus.cout, bus.ovf}), W'(0));
    #20;
    @(negedge clk) rst = 1'b0;

    run_op("carry ripple", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 0);
    run_op("full wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
    run_op("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
    run_op("sub borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("sub no borrow", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0, 0);
    run_op("sub ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
    run_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
           64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 10);

    // Reset two cycles into RUN: result discarded, block idle at once.
    @(negedge clk);
    bus.a = 64'h1234; bus.b = 64'h1; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrun rst out_valid", W'(bus.out_valid), W'(0));
    chk("midrun rst in_ready", W'(bus.in_ready), W'(1));
    chk("midrun rst sum", bus.sum, '0);
    $display("[TB] midrun reset: out_valid=%0d in_ready=%0d sum=%h",
             bus.out_valid, bus.in_ready, bus.sum);
    @(negedge clk) rst = 1'b0;
    run_op("after reset", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 16-bit slices; operand width W = 16*NWORDS.
REQ-002 SHALL have ports:
- clk, input, 1: the single clock, rising-edge active.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operand set offered.
- in_ready, output, 1: block can accept an operand set.
- a, input, W: operand A.
- b, input, W: operand B.
- sub, input, 1: 0 selects A+B, 1 selects A-B.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result.
- sum, output, W: result.
- cout, output, 1: final carry; for sub, 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow.
REQ-003 SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.

Function
REQ-004 SHALL compute the W-bit operation with one shared 16-bit carry-lookahead adder, processing one slice per cycle, LSB slice first.
REQ-005 SHALL have FSM states IDLE, RUN and DONE.
REQ-006 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-007 SHALL perform these actions on an accept edge (IDLE with in_valid=1):
- register a and sub;
- register b, bit-inverted when sub=1;
- set carry register to sub;
- clear slice index to 0;
- enter RUN.
REQ-008 SHALL perform these actions on each RUN cycle:
- adder slice inputs = registered a, b words [16*idx+15:16*idx]; adder cin = carry register;
- write the adder sum into sum slice idx;
- write adder cout into the carry register;
- increment idx.
REQ-009 SHALL, on the RUN cycle with idx = NWORDS-1, perform these actions:
- latch cout;
- compute ovf = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), where b' is the registered, possibly inverted b;
- enter DONE.
REQ-010 SHALL raise out_valid exactly NWORDS rising edges after the accept edge, which gives fixed latency NWORDS+1 cycles from in_valid sampled high.
REQ-011 SHALL hold sum, cout and ovf stable in DONE for as long as out_ready=0.
REQ-012 SHALL return to IDLE on the edge where out_valid & out_ready; in_ready rises in the following cycle, with no accept in the same cycle as result delivery.
REQ-013 SHALL ignore in_valid and operand changes while in RUN or DONE; operands are used only as captured.
REQ-014 SHALL let idx wrap only by reset or by a new accept; idx never exceeds NWORDS-1.
REQ-015 SHALL keep sum, cout and ovf at their last values, and drop out_valid, after a DONE-to-IDLE transition.
REQ-016 SHALL deliver A-B = A + ~B + 1 exactly; for sub, cout=1 iff A >= B unsigned.

Reset
REQ-017 SHALL, while rst=1 (asynchronously, independent of clk), force:
- state = IDLE, idx = 0, carry register = 0;
- all operand registers = 0;
- sum = 0, cout = 0, ovf = 0;
- out_valid = 0, in_ready = 1.
REQ-018 SHALL abort a RUN or DONE operation when rst asserts mid-operation, with no result delivered; the first accept after rst deasserts starts a fresh operation.

Structure
REQ-019 SHALL take the following from the shared package:
- state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
- slice width constant 16.
REQ-020 SHALL instantiate exactly one cla16bit as its sole sub-module; no other adder logic beyond the ovf compare.
REQ-021 SHALL use an index counter of clog2(NWORDS) bits (minimum 1).

Verification
REQ-022 SHALL be verified with these directed scenarios:
- Add, carry ripple: NWORDS=4, a=64'h0000_0000_FFFF_FFFF, b=64'h1, sub=0 -> out_valid at accept+4 edges, sum=64'h0000_0001_0000_0000, cout=0, ovf=0.
- Full wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, sub=0 -> sum=0, cout=1, ovf=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=64'h1, sub=0 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
- Subtract with borrow: a=64'h5, b=64'h7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; with a=7, b=5 -> sum=2, cout=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/cout/ovf stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
- Reset mid-RUN: assert rst 2 cycles after accept -> immediately out_valid=0, in_ready=1, sum=0; next operation 3+4 -> sum=7 at normal latency.
